// File: rtl/gpio_in_filter_if.sv
// Port-A input conditioning bus: raw pads and filter controls in,
// conditioned level and edge pulses out.
interface gpio_in_filter_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] filt_en;
   logic [CNT_W-1:0] filt_len;
   logic [WIDTH-1:0] filt_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;

   // Drives the pads and filter controls, observes the conditioned result.
   modport master (
      output pad_in, filt_en, filt_len,
      input  filt_out, rise_pulse, fall_pulse
   );

   // The filter itself.
   modport slave (
      input  pad_in, filt_en, filt_len,
      output filt_out, rise_pulse, fall_pulse
   );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: 2-flop synchroniser plus optional per-bit debounce in
// front of gpio_ext_porta. Emits one-cycle rise/fall pulses that line up
// with the new filt_out value.
module gpio_in_filter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   gpio_in_filter_if.slave   bus
);

   logic [WIDTH-1:0]            sync1_q, sync2_q;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            filt_q, filt_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic [CNT_W-1:0]            len_m1;

   // filt_len==0 behaves as 1, so the compare threshold is L_eff-1.
   // Recomputed every cycle; lowering filt_len mid-count takes effect at once.
   always_comb begin
      len_m1 = (bus.filt_len == '0) ? '0 : bus.filt_len - CNT_W'(1);
   end

   // Per-bit debounce decision and edge-pulse generation.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (!bus.filt_en[i]) begin
            filt_d[i] = sync2_q[i];
         end else if (sync2_q[i] ^ filt_q[i]) begin
            // >= rather than == so the counter can never run past the
            // threshold, even when filt_len shrinks below the current count.
            if (cnt_q[i] >= len_m1) filt_d[i] = sync2_q[i];
            else                    cnt_d[i]  = cnt_q[i] + CNT_W'(1);
         end
      end
      rise_d = ~filt_q &  filt_d;
      fall_d =  filt_q & ~filt_d;
   end

   // All state: synchroniser, counters, conditioned level and pulses.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         filt_q  <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         sync1_q <= bus.pad_in;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign bus.filt_out   = filt_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: expected outputs are queued with the cycle they
// are due when stimulus is applied, and compared when that cycle arrives.
module tb_gpio_in_filter;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   gpio_in_filter_if #(.WIDTH(8), .CNT_W(8)) bus ();

   gpio_in_filter #(.WIDTH(8), .CNT_W(8)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus.slave)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      string      tag;
      logic [7:0] filt;
      logic [7:0] rise;
      logic [7:0] fall;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expect the outputs k edges after the current cycle.
   task automatic push(input string tag, input int k,
                       input logic [7:0] f, input logic [7:0] r, input logic [7:0] fl);
      exp_t e;
      e.due = cyc + k; e.tag = tag; e.filt = f; e.rise = r; e.fall = fl;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 300) begin
         @(negedge pclk);
         t++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   // Compare outputs against every expectation due at this cycle.
   always @(negedge pclk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due < cyc) chk({e.tag, "_missed"}, e.due, cyc);
         else begin
            chk({e.tag, "_filt"}, bus.filt_out, e.filt);
            chk({e.tag, "_rise"}, bus.rise_pulse, e.rise);
            chk({e.tag, "_fall"}, bus.fall_pulse, e.fall);
         end
      end
   end

   initial begin
      bus.pad_in   = 8'hFF;
      bus.filt_en  = 8'h00;
      bus.filt_len = 8'd0;

      // 1: reset with pads high, then release
      idle(3);
      chk("rst_filt", bus.filt_out, 8'h00);
      chk("rst_rise", bus.rise_pulse, 8'h00);
      chk("rst_fall", bus.fall_pulse, 8'h00);
      presetn = 1'b1;
      push("rel_e2", 2, 8'h00, 8'h00, 8'h00);
      push("rel_e3", 3, 8'hFF, 8'hFF, 8'h00);
      push("rel_e4", 4, 8'hFF, 8'h00, 8'h00);
      drain();

      // 2: bypass rise on bit 0
      bus.pad_in = 8'h00;
      idle(6);
      bus.pad_in = 8'h01;
      push("byp_e2", 2, 8'h00, 8'h00, 8'h00);
      push("byp_e3", 3, 8'h01, 8'h01, 8'h00);
      push("byp_e4", 4, 8'h01, 8'h00, 8'h00);
      drain();

      // 3: debounce with filt_len=4
      bus.pad_in = 8'h00;
      idle(6);
      bus.filt_en  = 8'h01;
      bus.filt_len = 8'd4;
      bus.pad_in   = 8'h01;
      push("db_rise_e5", 5, 8'h00, 8'h00, 8'h00);
      push("db_rise_e6", 6, 8'h01, 8'h01, 8'h00);
      push("db_rise_e7", 7, 8'h01, 8'h00, 8'h00);
      drain();
      bus.pad_in = 8'h00;
      push("db_fall_e5", 5, 8'h01, 8'h00, 8'h00);
      push("db_fall_e6", 6, 8'h00, 8'h00, 8'h01);
      drain();
      idle(2);
      bus.pad_in = 8'h01;
      for (int k = 1; k <= 10; k++) push("glitch", k, 8'h00, 8'h00, 8'h00);
      idle(3);
      bus.pad_in = 8'h00;
      drain();

      // 4: filt_len 0 and 1 match bypass latency
      bus.filt_len = 8'd0;
      bus.pad_in   = 8'h01;
      push("len0_e2", 2, 8'h00, 8'h00, 8'h00);
      push("len0_e3", 3, 8'h01, 8'h01, 8'h00);
      drain();
      idle(2);
      bus.filt_len = 8'd1;
      bus.pad_in   = 8'h00;
      push("len1_e2", 2, 8'h01, 8'h00, 8'h00);
      push("len1_e3", 3, 8'h00, 8'h00, 8'h01);
      drain();
      idle(2);

      // 5a: filt_len lowered from 200 to 10 once cnt has reached 50
      bus.filt_len = 8'd200;
      bus.pad_in   = 8'h01;
      push("lenchg_e52", 52, 8'h00, 8'h00, 8'h00);
      push("lenchg_e53", 53, 8'h01, 8'h01, 8'h00);
      idle(52);
      bus.filt_len = 8'd10;
      drain();
      idle(2);

      // 5b: filt_en dropped mid-count, then re-enabled counts from 0
      bus.filt_len = 8'd200;
      bus.pad_in   = 8'h00;
      push("endrop_e20", 20, 8'h01, 8'h00, 8'h00);
      push("endrop_e21", 21, 8'h00, 8'h00, 8'h01);
      idle(20);
      bus.filt_en = 8'h00;
      drain();
      bus.filt_en  = 8'h01;
      bus.filt_len = 8'd5;
      bus.pad_in   = 8'h01;
      push("reen_e6", 6, 8'h00, 8'h00, 8'h00);
      push("reen_e7", 7, 8'h01, 8'h01, 8'h00);
      drain();

      // 6: bit0 rises and bit7 falls together, filt_len=2
      bus.filt_en = 8'h00;
      bus.pad_in  = 8'h80;
      idle(6);
      bus.filt_en  = 8'h81;
      bus.filt_len = 8'd2;
      bus.pad_in   = 8'h01;
      push("ind_e3", 3, 8'h80, 8'h00, 8'h00);
      push("ind_e4", 4, 8'h01, 8'h01, 8'h80);
      push("ind_e5", 5, 8'h01, 8'h00, 8'h00);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
